// File: rtl/pu_or1k_wb_arbiter.sv
// Purpose: Wishbone B3 shared-bus interconnect, MASTERS initiators round-robin onto SLAVES base/mask windows.
// Latency: grant one cycle after cyc; slave responses reach the granted master combinationally (0 added cycles).
// Backpressure: a held grant is never preempted; others wait; one idle cycle between grants; default-slave and timeout errors.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   m_*_i / m_*_o               packed per-master Wishbone initiator ports (master i at slice i)
//   s_adr/dat/sel/we/cti/bte_o  shared bus, broadcast to every slave
//   s_cyc_o, s_stb_o            per-slave cycle/strobe, only the decoded slave is driven
//   s_dat_i, s_ack/err/rty_i    packed per-slave responses
//   grant_o                     one-hot current grant (zero while idle)
module pu_or1k_wb_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MASTERS = 3,
   parameter int SLAVES  = 2,
   // slave i occupies slice [i*AW +: AW], so slave 0 is the rightmost word
   parameter logic [SLAVES*AW-1:0] SLAVE_BASE = {32'h90000000, 32'h00000000},
   parameter logic [SLAVES*AW-1:0] SLAVE_MASK = {32'hFFFFFFF8, 32'hFE000000},
   parameter int TIMEOUT = 255
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic [MASTERS*AW-1:0]   m_adr_i,
   input  logic [MASTERS*DW-1:0]   m_dat_i,
   input  logic [MASTERS*DW/8-1:0] m_sel_i,
   input  logic [MASTERS-1:0]      m_we_i,
   input  logic [MASTERS-1:0]      m_cyc_i,
   input  logic [MASTERS-1:0]      m_stb_i,
   input  logic [MASTERS*3-1:0]    m_cti_i,
   input  logic [MASTERS*2-1:0]    m_bte_i,
   output logic [MASTERS*DW-1:0]   m_dat_o,
   output logic [MASTERS-1:0]      m_ack_o,
   output logic [MASTERS-1:0]      m_err_o,
   output logic [MASTERS-1:0]      m_rty_o,
   output logic [AW-1:0]           s_adr_o,
   output logic [DW-1:0]           s_dat_o,
   output logic [DW/8-1:0]         s_sel_o,
   output logic                    s_we_o,
   output logic [2:0]              s_cti_o,
   output logic [1:0]              s_bte_o,
   output logic [SLAVES-1:0]       s_cyc_o,
   output logic [SLAVES-1:0]       s_stb_o,
   input  logic [SLAVES*DW-1:0]    s_dat_i,
   input  logic [SLAVES-1:0]       s_ack_i,
   input  logic [SLAVES-1:0]       s_err_i,
   input  logic [SLAVES-1:0]       s_rty_i,
   output logic [MASTERS-1:0]      grant_o
);

   localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int BW = DW / 8;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state, state_nxt;
   // last_grant doubles as the index of the current owner while BUSY
   logic [IW-1:0] last_grant, last_grant_nxt, winner;
   logic [CW-1:0] to_cnt, to_cnt_nxt;
   logic          err_def, err_def_nxt;
   logic          busy, g_cyc, g_stb, to_hit, fwd, any_resp;
   logic [AW-1:0] g_adr;
   logic          sel_vld;
   logic [SW-1:0] sel_idx;

   // Round-robin search: scanning distances from far to near lets the
   // nearest requester above last_grant overwrite the others.
   always_comb begin
      int idx;
      idx    = 0;
      winner = last_grant;
      for (int d = MASTERS; d >= 1; d--) begin
         idx = (int'(last_grant) + d) % MASTERS;
         if (m_cyc_i[idx]) winner = IW'(idx);
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      case (state)
         IDLE: begin
            if (|m_cyc_i) begin
               state_nxt      = BUSY;
               last_grant_nxt = winner;
            end
         end
         BUSY: begin
            if (!m_cyc_i[last_grant]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy  = (state == BUSY);
   assign g_cyc = busy && m_cyc_i[last_grant];
   assign g_stb = g_cyc && m_stb_i[last_grant];
   assign g_adr = m_adr_i[int'(last_grant)*AW +: AW];

   // Address decode: lowest-index matching window wins.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int i = SLAVES - 1; i >= 0; i--) begin
         if ((g_adr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) begin
            sel_vld = 1'b1;
            sel_idx = SW'(i);
         end
      end
   end

   // Timeout fires on the cycle the wait count reaches TIMEOUT; the strobe is
   // withdrawn that cycle so a late slave ack cannot complete the transfer.
   assign to_hit   = (TIMEOUT != 0) && g_stb && (to_cnt == CW'(TIMEOUT));
   assign fwd      = g_stb && !to_hit && sel_vld;
   assign any_resp = (fwd && (s_ack_i[sel_idx] || s_err_i[sel_idx] || s_rty_i[sel_idx])) || err_def;

   always_comb begin
      to_cnt_nxt = to_cnt;
      if (!g_stb || any_resp || to_hit)
         to_cnt_nxt = '0;
      else if ((TIMEOUT != 0) && (to_cnt != CW'(TIMEOUT)))
         to_cnt_nxt = to_cnt + CW'(1);
   end

   // Default slave: one-cycle error pulse, then a gap so a master that keeps
   // strobing sees discrete errors.
   assign err_def_nxt = g_stb && !sel_vld && !err_def;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         last_grant <= IW'(MASTERS - 1);
         to_cnt     <= '0;
         err_def    <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         to_cnt     <= to_cnt_nxt;
         err_def    <= err_def_nxt;
      end
   end

   assign grant_o = busy ? (MASTERS'(1) << last_grant) : '0;

   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      s_cti_o = '0;
      s_bte_o = '0;
      s_cyc_o = '0;
      s_stb_o = '0;
      if (busy) begin
         s_adr_o = g_adr;
         s_dat_o = m_dat_i[int'(last_grant)*DW +: DW];
         s_sel_o = m_sel_i[int'(last_grant)*BW +: BW];
         s_we_o  = m_we_i[last_grant];
         s_cti_o = m_cti_i[int'(last_grant)*3 +: 3];
         s_bte_o = m_bte_i[int'(last_grant)*2 +: 2];
         if (sel_vld) begin
            s_cyc_o[sel_idx] = g_cyc;
            s_stb_o[sel_idx] = g_stb && !to_hit;
         end
      end
   end

   always_comb begin
      m_dat_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      m_rty_o = '0;
      if (busy) begin
         if (sel_vld) m_dat_o[int'(last_grant)*DW +: DW] = s_dat_i[int'(sel_idx)*DW +: DW];
         m_ack_o[last_grant] = fwd && s_ack_i[sel_idx];
         m_err_o[last_grant] = (fwd && s_err_i[sel_idx]) || err_def || to_hit;
         m_rty_o[last_grant] = fwd && s_rty_i[sel_idx];
      end
   end

endmodule

// File: tb/tb_pu_or1k_wb_arbiter.sv
// Bench for pu_or1k_wb_arbiter: directed scenarios plus randomized request rounds,
// checked against a transaction-level model (round-robin pick, address ranges, slave latency).
module tb_pu_or1k_wb_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NM = 3;
   localparam int NS = 2;
   localparam int TO = 4;

   logic                 wb_clk_i = 1'b0;
   logic                 wb_rst_i;
   logic [NM*AW-1:0]     m_adr_i;
   logic [NM*DW-1:0]     m_dat_i;
   logic [NM*DW/8-1:0]   m_sel_i;
   logic [NM-1:0]        m_we_i, m_cyc_i, m_stb_i;
   logic [NM*3-1:0]      m_cti_i;
   logic [NM*2-1:0]      m_bte_i;
   logic [NM*DW-1:0]     m_dat_o;
   logic [NM-1:0]        m_ack_o, m_err_o, m_rty_o;
   logic [AW-1:0]        s_adr_o;
   logic [DW-1:0]        s_dat_o;
   logic [DW/8-1:0]      s_sel_o;
   logic                 s_we_o;
   logic [2:0]           s_cti_o;
   logic [1:0]           s_bte_o;
   logic [NS-1:0]        s_cyc_o, s_stb_o;
   logic [NS*DW-1:0]     s_dat_i;
   logic [NS-1:0]        s_ack_i, s_err_i, s_rty_i;
   logic [NM-1:0]        grant_o;

   int          lat[NS];
   int          wcnt[NS];
   logic [31:0] sdat[NS];
   logic [31:0] madr[NM];
   logic        mwe[NM];
   int          ncmp = 0;
   int          nfail = 0;
   int          m_last;

   pu_or1k_wb_arbiter #(
      .AW(AW), .DW(DW), .MASTERS(NM), .SLAVES(NS),
      .SLAVE_BASE({32'h90000000, 32'h00000000}),
      .SLAVE_MASK({32'hFFFFFFF8, 32'hFE000000}),
      .TIMEOUT(TO)
   ) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
      .grant_o(grant_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Slave model: acks after its strobe has been held for lat[i] cycles.
   assign s_dat_i = {sdat[1], sdat[0]};
   always_comb begin
      for (int i = 0; i < NS; i++) s_ack_i[i] = s_stb_o[i] && (wcnt[i] == lat[i]);
   end
   always @(posedge wb_clk_i) begin
      for (int j = 0; j < NS; j++) wcnt[j] <= (s_stb_o[j] && !s_ack_i[j]) ? wcnt[j] + 1 : 0;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sample/drive point: 2 ns after the rising edge.
   task automatic step();
      @(posedge wb_clk_i);
      #2;
   endtask

   function automatic int rr_pick(input int last, input logic [NM-1:0] req);
      for (int d = 1; d <= NM; d++) if (req[(last + d) % NM]) return (last + d) % NM;
      return -1;
   endfunction

   // Address map as plain ranges: 32 MB at 0 for slave 0, 8 bytes at 0x90000000 for slave 1.
   function automatic int target(input logic [31:0] a);
      if (a < 32'h0200_0000) return 0;
      if (a >= 32'h9000_0000 && a <= 32'h9000_0007) return 1;
      return -1;
   endfunction

   task automatic set_m(input int i, input logic cyc, input logic [31:0] adr, input logic we,
                        input logic [2:0] cti);
      m_cyc_i[i]           = cyc;
      m_stb_i[i]           = cyc;
      m_adr_i[i*AW +: AW]  = adr;
      m_we_i[i]            = we;
      m_cti_i[i*3 +: 3]    = cti;
      m_dat_i[i*DW +: DW]  = adr ^ 32'hA5A5_0000;
      m_sel_i[i*4 +: 4]    = 4'hF;
   endtask

   task automatic wait_resp(input int w, input int lim, output int k, output int kind);
      k = 0;
      kind = 0;
      while (1) begin
         if (m_ack_o[w]) kind = 1;
         else if (m_err_o[w]) kind = 2;
         else if (m_rty_o[w]) kind = 3;
         if (kind != 0 || k > lim) break;
         step();
         k++;
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'(|{grant_o, s_cyc_o, s_stb_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o,
                   s_bte_o, m_dat_o, m_ack_o, m_err_o, m_rty_o});
   endfunction

   // Requesters in req each perform `reps` single accesses; served masters re-request
   // during the idle cycle so the round-robin order is exercised under contention.
   task automatic run_round(input logic [NM-1:0] req, input int reps);
      int left[NM];
      logic [NM-1:0] pend;
      int w, k, kind, t, ek, ekind;
      pend = req;
      for (int i = 0; i < NM; i++) begin
         left[i] = req[i] ? reps : 0;
         if (req[i]) set_m(i, 1'b1, madr[i], mwe[i], 3'b000);
      end
      while (pend != 0) begin
         step();
         w = rr_pick(m_last, pend);
         m_last = w;
         check("grant", 64'(grant_o), 64'(1) << w);
         t = target(madr[w]);
         if (t < 0) begin ekind = 2; ek = 1; end
         else if (lat[t] >= TO) begin ekind = 2; ek = TO; end
         else begin ekind = 1; ek = lat[t]; end
         wait_resp(w, 12, k, kind);
         check("resp_kind", 64'(kind), 64'(ekind));
         check("resp_cycle", 64'(k), 64'(ek));
         check("resp_owner_only", 64'(m_ack_o | m_err_o | m_rty_o), 64'(1) << w);
         check("s_adr", 64'(s_adr_o), 64'(madr[w]));
         check("s_we", 64'(s_we_o), 64'(mwe[w]));
         check("s_cyc_decode", 64'(s_cyc_o), (t < 0) ? 64'(0) : (64'(1) << t));
         if (ekind == 1) check("rdata", 64'(m_dat_o[w*DW +: DW]), 64'(sdat[t]));
         else if (t >= 0) check("stb_low_on_timeout", 64'(s_stb_o), 64'(0));
         set_m(w, 1'b0, madr[w], mwe[w], 3'b000);
         left[w]--;
         if (left[w] == 0) pend[w] = 1'b0;
         step();
         check("turnaround_idle", 64'(grant_o), 64'(0));
         if (left[w] != 0) set_m(w, 1'b1, madr[w], mwe[w], 3'b000);
      end
   endtask

   task automatic burst_lock();
      int k, kind, nack, w;
      lat[0] = 1; lat[1] = 15;
      sdat[0] = $urandom;
      madr[2] = 32'h0000_0200;
      mwe[2] = 1'b1;
      set_m(0, 1'b1, 32'h0000_0100, 1'b0, 3'b010);
      step();
      w = rr_pick(m_last, 3'b001);
      m_last = w;
      check("burst_grant", 64'(grant_o), 64'(1) << w);
      set_m(2, 1'b1, madr[2], 1'b1, 3'b000);
      nack = 0;
      for (int b = 0; b < 4; b++) begin
         wait_resp(0, 6, k, kind);
         check("burst_beat_ack", 64'(kind), 64'(1));
         check("burst_hold_grant", 64'(grant_o), 64'(3'b001));
         check("burst_m2_quiet", 64'(m_ack_o[2] | m_err_o[2]), 64'(0));
         if (kind == 1) nack++;
         if (b < 3) begin
            set_m(0, 1'b1, 32'h0000_0100 + 32'(4 * (b + 1)), 1'b0, (b == 2) ? 3'b111 : 3'b010);
            step();
         end
      end
      check("burst_ack_count", 64'(nack), 64'(4));
      set_m(0, 1'b0, 32'h0, 1'b0, 3'b000);
      step();
      check("burst_release_idle", 64'(grant_o), 64'(0));
      step();
      w = rr_pick(m_last, 3'b100);
      m_last = w;
      check("burst_next_grant", 64'(grant_o), 64'(1) << w);
      check("burst_next_stb", 64'(s_stb_o), 64'(2'b01));
      m_cyc_i[2] = 1'b0;
      #1;
      check("cyc_drop_kills_cyc", 64'(s_cyc_o), 64'(0));
      check("cyc_drop_kills_stb", 64'(s_stb_o), 64'(0));
      m_stb_i[2] = 1'b0;
      step();
      check("cyc_drop_idle", 64'(grant_o), 64'(0));
   endtask

   task automatic reset_mid();
      int k, kind, w;
      lat[0] = 1; lat[1] = 15;
      set_m(1, 1'b1, 32'h0000_0300, 1'b0, 3'b010);
      step();
      w = rr_pick(m_last, 3'b010);
      m_last = w;
      check("rst_burst_grant", 64'(grant_o), 64'(1) << w);
      wait_resp(1, 6, k, kind);
      check("rst_beat1_ack", 64'(kind), 64'(1));
      set_m(1, 1'b1, 32'h0000_0304, 1'b0, 3'b010);
      step();
      check("rst_beat2_active", 64'(s_stb_o), 64'(2'b01));
      #1;
      wb_rst_i = 1'b1;
      #1;
      check("rst_async_grant", 64'(grant_o), 64'(0));
      check("rst_async_outs", all_outs(), 64'(0));
      step();
      step();
      wb_rst_i = 1'b0;
      m_last = NM - 1;
      madr[0] = 32'h0000_1000; madr[1] = 32'h0000_2000; madr[2] = 32'h9000_0000;
      mwe[0] = 1'b0; mwe[1] = 1'b1; mwe[2] = 1'b0;
      lat[1] = 2;
      run_round(3'b111, 2);
   endtask

   initial begin
      logic [NM-1:0] req;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
      m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0; m_bte_i = '0;
      s_err_i = '0; s_rty_i = '0;
      lat[0] = 1; lat[1] = 15;
      sdat[0] = 32'hDEADBEEF; sdat[1] = 32'h1234_5678;
      for (int i = 0; i < NM; i++) begin madr[i] = '0; mwe[i] = 1'b0; end
      wb_rst_i = 1'b1;
      #1;
      check("reset_grant", 64'(grant_o), 64'(0));
      check("reset_outs", all_outs(), 64'(0));
      step();
      step();
      wb_rst_i = 1'b0;
      m_last = NM - 1;

      // single read by master 1 to slave 0
      madr[1] = 32'h0000_0040;
      run_round(3'b010, 1);

      // three masters contending, two accesses each
      madr[0] = 32'h0000_0010; madr[1] = 32'h0000_0020; madr[2] = 32'h9000_0004;
      lat[1] = 2;
      run_round(3'b111, 2);

      // unmapped address goes to the default slave
      madr[1] = 32'h5000_0000;
      run_round(3'b010, 1);

      // silent slave 1 triggers the bus timeout
      madr[2] = 32'h9000_0000;
      lat[1] = 15;
      run_round(3'b100, 1);

      burst_lock();

      for (int it = 0; it < 25; it++) begin
         req = NM'($urandom_range(1, (1 << NM) - 1));
         for (int i = 0; i < NM; i++) begin
            case ($urandom_range(0, 2))
               0: madr[i] = $urandom & 32'h01FF_FFFC;
               1: madr[i] = 32'h9000_0000 | ($urandom & 32'h4);
               default: madr[i] = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
            endcase
            mwe[i] = 1'($urandom);
         end
         lat[0] = $urandom_range(1, 5);
         lat[1] = $urandom_range(1, 5);
         sdat[0] = $urandom;
         sdat[1] = $urandom;
         run_round(req, $urandom_range(1, 2));
      end

      reset_mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
